// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating stall counter.
// Latency: one cycle from ID inputs to idex_* outputs; hazard outputs are combinational from registered state.
// Backpressure: on a load-use hazard it drops pc_write/ifid_write and loads a bubble so ID re-presents its instruction.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [4:0]        ifid_rs,
  input  logic [4:0]        ifid_rt,
  input  logic [4:0]        ifid_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush_i,
  output logic [4:0]        idex_regs,
  output logic [4:0]        idex_regt,
  output logic [4:0]        idex_regd,
  output logic [DATA_W-1:0] idex_rs_data,
  output logic [DATA_W-1:0] idex_rt_data,
  output logic [DATA_W-1:0] idex_imm,
  output logic [CTRL_W-1:0] idex_ctrl,
  output logic              idex_valid,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int MEMREAD_BIT = 1;

  typedef struct packed {
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
  } idex_t;

  idex_t            stage_q;
  idex_t            stage_d;
  logic             hazard;
  logic [CNT_W-1:0] cnt_q;

  // A load writing $0 never produces a usable value, so it cannot cause a stall.
  assign hazard = stage_q.ctrl[MEMREAD_BIT] & (stage_q.rt != 5'd0) &
                  ((stage_q.rt == ifid_rs) | (stage_q.rt == ifid_rt));

  always_comb begin
    stage_d = '0;
    if (!(flush_i | hazard)) begin
      stage_d.rs      = ifid_rs;
      stage_d.rt      = ifid_rt;
      stage_d.rd      = ifid_rd;
      stage_d.rs_data = id_rs_data;
      stage_d.rt_data = id_rt_data;
      stage_d.imm     = id_imm;
      stage_d.ctrl    = id_ctrl;
      stage_d.valid   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Flushed cycles are not counted: the squash, not the dependency, caused the bubble.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (hazard && !flush_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign idex_regs    = stage_q.rs;
  assign idex_regt    = stage_q.rt;
  assign idex_regd    = stage_q.rd;
  assign idex_rs_data = stage_q.rs_data;
  assign idex_rt_data = stage_q.rt_data;
  assign idex_imm     = stage_q.imm;
  assign idex_ctrl    = stage_q.ctrl;
  assign idex_valid   = stage_q.valid;
  assign stall_o      = hazard;
  assign pc_write     = ~hazard;
  assign ifid_write   = ~hazard;
  assign stall_count  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with an instruction-level reference model checked every cycle.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic [4:0]        ifid_rs = '0, ifid_rt = '0, ifid_rd = '0;
  logic [DATA_W-1:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic [CTRL_W-1:0] id_ctrl = '0;
  logic              flush_i = 1'b0;
  logic [4:0]        idex_regs, idex_regt, idex_regd;
  logic [DATA_W-1:0] idex_rs_data, idex_rt_data, idex_imm;
  logic [CTRL_W-1:0] idex_ctrl;
  logic              idex_valid, pc_write, ifid_write, stall_o;
  logic [CNT_W-1:0]  stall_count;

  int vectors = 0;
  int miscompares = 0;

  id_ex_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_rd(ifid_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .flush_i(flush_i),
    .idex_regs(idex_regs), .idex_regt(idex_regt), .idex_regd(idex_regd),
    .idex_rs_data(idex_rs_data), .idex_rt_data(idex_rt_data), .idex_imm(idex_imm),
    .idex_ctrl(idex_ctrl), .idex_valid(idex_valid),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .stall_o(stall_o), .stall_count(stall_count)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the instruction sitting in EX, and the count of dependency stalls.
  logic              m_v;
  int                m_rs, m_rt, m_rd;
  logic [DATA_W-1:0] m_rsd, m_rtd, m_imm;
  logic [CTRL_W-1:0] m_ctrl;
  int                m_cnt;

  // ID must wait when EX holds a load whose (non-$0) destination ID reads.
  function automatic bit load_use();
    bit ex_is_load = m_ctrl[1];
    bit reads_it   = (m_rt == int'(ifid_rs)) || (m_rt == int'(ifid_rt));
    return ex_is_load && (m_rt != 0) && reads_it;
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_v <= 0; m_rs <= 0; m_rt <= 0; m_rd <= 0;
      m_rsd <= '0; m_rtd <= '0; m_imm <= '0; m_ctrl <= '0; m_cnt <= 0;
    end else begin
      if (flush_i || load_use()) begin
        m_v <= 0; m_rs <= 0; m_rt <= 0; m_rd <= 0;
        m_rsd <= '0; m_rtd <= '0; m_imm <= '0; m_ctrl <= '0;
      end else begin
        m_v <= 1; m_rs <= int'(ifid_rs); m_rt <= int'(ifid_rt); m_rd <= int'(ifid_rd);
        m_rsd <= id_rs_data; m_rtd <= id_rt_data; m_imm <= id_imm; m_ctrl <= id_ctrl;
      end
      if (load_use() && !flush_i) m_cnt <= (m_cnt + 1 > SAT) ? SAT : m_cnt + 1;
    end
  end

  always @(negedge clk_i) begin
    check("regs",    64'(idex_regs),    64'(m_rs));
    check("regt",    64'(idex_regt),    64'(m_rt));
    check("regd",    64'(idex_regd),    64'(m_rd));
    check("rs_data", 64'(idex_rs_data), 64'(m_rsd));
    check("rt_data", 64'(idex_rt_data), 64'(m_rtd));
    check("imm",     64'(idex_imm),     64'(m_imm));
    check("ctrl",    64'(idex_ctrl),    64'(m_ctrl));
    check("valid",   64'(idex_valid),   64'(m_v));
    check("stall",   64'(stall_o),      64'(load_use()));
    check("pc_wr",   64'(pc_write),     64'(!load_use()));
    check("ifid_wr", 64'(ifid_write),   64'(!load_use()));
    check("count",   64'(stall_count),  64'(m_cnt));
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drive(input int rs, input int rt, input int rd, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic [31:0] imm, input logic [7:0] ctrl,
                       input logic fl);
    ifid_rs = 5'(rs); ifid_rt = 5'(rt); ifid_rd = 5'(rd);
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_ctrl = ctrl; flush_i = fl;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #22 rst_i = 1'b1;
    #1;
    check("rst_valid", 64'(idex_valid), 64'h0);
    check("rst_cnt",   64'(stall_count), 64'h0);
    check("rst_pcw",   64'(pc_write), 64'h1);

    // Plain capture.
    tick();
    drive(1, 2, 3, 32'h11, 32'h22, 32'h33, 8'h21, 1'b0);
    tick();
    #1;
    check("cap_regs", 64'(idex_regs), 64'd1);
    check("cap_regt", 64'(idex_regt), 64'd2);
    check("cap_regd", 64'(idex_regd), 64'd3);
    check("cap_rsd",  64'(idex_rs_data), 64'h11);
    check("cap_ctrl", 64'(idex_ctrl), 64'h21);
    check("cap_vld",  64'(idex_valid), 64'h1);

    // Load-use: lw $5, then add reading $5.
    drive(0, 5, 0, 32'h0, 32'h0, 32'h4, 8'h0B, 1'b0);
    tick();
    drive(5, 6, 7, 32'h55, 32'h66, 32'h0, 8'h21, 1'b0);
    #1;
    check("lu_stall", 64'(stall_o), 64'h1);
    check("lu_pcw",   64'(pc_write), 64'h0);
    check("lu_ifw",   64'(ifid_write), 64'h0);
    tick();
    #1;
    check("lu_bub_ctrl", 64'(idex_ctrl), 64'h0);
    check("lu_bub_vld",  64'(idex_valid), 64'h0);
    check("lu_clear",    64'(stall_o), 64'h0);
    check("lu_cnt",      64'(stall_count), 64'h1);
    tick();
    #1;
    check("lu_add_rs",  64'(idex_regs), 64'd5);
    check("lu_add_vld", 64'(idex_valid), 64'h1);

    // Load into $0 never stalls.
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 8'h03, 1'b0);
    tick();
    drive(0, 0, 9, 32'h1, 32'h2, 32'h0, 8'h21, 1'b0);
    #1;
    check("z_stall", 64'(stall_o), 64'h0);
    check("z_pcw",   64'(pc_write), 64'h1);
    tick();
    #1;
    check("z_cnt", 64'(stall_count), 64'h1);

    // Flush beats hazard and is not counted.
    drive(0, 9, 0, 32'h0, 32'h0, 32'h0, 8'h03, 1'b0);
    tick();
    drive(9, 1, 2, 32'h9, 32'h1, 32'h0, 8'h21, 1'b1);
    #1;
    check("fl_stall", 64'(stall_o), 64'h1);
    tick();
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 8'h00, 1'b0);
    #1;
    check("fl_vld", 64'(idex_valid), 64'h0);
    check("fl_cnt", 64'(stall_count), 64'h1);

    // Load, dependent load, then a consumer of the second load: one stall each.
    drive(0, 4, 0, 32'h0, 32'h0, 32'h0, 8'h0B, 1'b0);
    tick();
    drive(4, 8, 0, 32'h0, 32'h0, 32'h8, 8'h0B, 1'b0);
    tick(); tick();
    drive(8, 3, 10, 32'h0, 32'h0, 32'h0, 8'h21, 1'b0);
    tick(); tick();
    #1;
    check("b2b_cnt",  64'(stall_count), 64'h3);
    check("b2b_regs", 64'(idex_regs), 64'd8);

    // Saturation: 20 more load-use pairs on a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      drive(0, 10, 0, 32'h0, 32'h0, 32'(i), 8'h03, 1'b0);
      tick();
      drive(10, 0, 11, 32'(i), 32'h0, 32'h0, 8'h21, 1'b0);
      tick(); tick();
    end
    #1;
    check("sat_cnt", 64'(stall_count), 64'hF);

    // Reset in the middle of a stall.
    drive(0, 12, 0, 32'h0, 32'h0, 32'h0, 8'h03, 1'b0);
    tick();
    drive(12, 0, 13, 32'h0, 32'h0, 32'h0, 8'h21, 1'b0);
    #1;
    check("mr_pre_ctrl", 64'(idex_ctrl), 64'h03);
    rst_i = 1'b0;
    #1;
    check("mr_ctrl",  64'(idex_ctrl), 64'h0);
    check("mr_vld",   64'(idex_valid), 64'h0);
    check("mr_regt",  64'(idex_regt), 64'h0);
    check("mr_pcw",   64'(pc_write), 64'h1);
    check("mr_stall", 64'(stall_o), 64'h0);
    check("mr_cnt",   64'(stall_count), 64'h0);
    #3 rst_i = 1'b1;
    tick();
    drive(7, 7, 7, 32'hDEAD, 32'hBEEF, 32'hFFFF_FFFC, 8'hC5, 1'b0);
    tick(); tick();
    #1;
    check("post_imm", 64'(idex_imm), 64'hFFFF_FFFC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
